snax_gemm_seq: RTL
==================

// Module: snax_gemm_seq
// PURPOSE
//  Control/sequencing front-end for the SNAX GEMM datapath. Decodes CSR requests from the core,
//  holds operand base addresses, and on a start command fetches A and B over the TCDM ports,
//  launches the GEMM compute, then stores C. The datapath owns data; this block owns addresses,
//  handshakes, phase ordering and status.
// PARAMETERS
//  AddrWidth      48  TCDM address width
//  DataWidth      64  TCDM word width; port i address stride = DataWidth/8 bytes
//  SnaxTcdmPorts  16  number of TCDM ports (P)
// PORTS
//  clk_i            in   1       clock
//  rst_i            in   1       synchronous reset, active-high
//  csr_req_valid_i  in   1       CSR request valid
//  csr_req_ready_o  out  1       CSR request ready
//  csr_req_write_i  in   1       1 = write (CSRRW), 0 = read (CSRRS)
//  csr_req_addr_i   in   32      CSR index
//  csr_req_data_i   in   32      CSR write data
//  csr_rsp_valid_o  out  1       CSR response valid
//  csr_rsp_ready_i  in   1       CSR response ready
//  csr_rsp_data_o   out  32      CSR read data (0 for writes)
//  tcdm_q_valid_o   out  P       per-port request valid
//  tcdm_q_ready_i   in   P       per-port request grant
//  tcdm_q_write_o   out  1       1 in STORE_C, else 0
//  tcdm_q_addr_o    out  P*AW    per-port address, port i in bits [i*AW +: AW]
//  tcdm_p_valid_i   in   P       per-port read response valid
//  load_a_o         out  P       datapath capture strobe for A, per port
//  load_b_o         out  P       datapath capture strobe for B, per port
//  gemm_start_o     out  1       one-cycle compute start pulse
//  gemm_done_i      in   1       datapath compute done (single-cycle pulse)
// BEHAVIOUR
//  Reset: all CSRs 0, state IDLE, every output 0 (csr_req_ready_o 0 during reset, 1 after).
//  CSR map: 0 addr_a, 1 addr_b, 2 addr_c (RW, 32b); 3 start (W, any data; reads 0);
//   4 status (RO: bit0 busy, bit1 done); other indices: writes dropped, reads 0.
//  CSR handshake: one outstanding; csr_req_ready_o = !csr_rsp_valid_o. Accept -> rsp valid next
//   cycle, held with stable data until csr_rsp_ready_i. Every accepted request gets one response.
//  Writes to 0..3 while busy: accepted, responded, no effect. Start in IDLE: clear done, go LOAD_A.
//  Addresses: base zero-extended to AW; port i = base + i*(DataWidth/8), modulo 2^AW (wrap).
//  States: IDLE -> LOAD_A -> LOAD_B -> COMPUTE -> STORE_C -> IDLE.
//  Load phase (A/B): on entry all tcdm_q_valid_o = 1; port i drops valid the cycle after its grant
//   (valid&ready). Granted mask G, response mask R. p_valid on port i counts only if G[i] was set in
//   an earlier cycle; else ignored. load_x_o[i] = counted p_valid[i]. Phase ends when G and R
//   all-ones; next state entered the following cycle, masks cleared.
//  COMPUTE: gemm_start_o high on first cycle only; wait for gemm_done_i; then STORE_C next cycle.
//   gemm_done_i outside COMPUTE ignored.
//  STORE_C: same per-port request scheme with tcdm_q_write_o = 1 on addr_c; ends when all granted
//   (no responses); then IDLE with done = 1.
//  busy = (state != IDLE). Addresses latched from CSRs at start; CSR changes mid-run have no effect.
//  Best case timing (all ready=1, p_valid 1 cycle after grant): start accepted cycle t -> LOAD_A t+1,
//   LOAD_B t+3, COMPUTE t+5 (gemm_start_o at t+5).
//  Reset mid-operation: immediate return to IDLE, all masks, CSRs, pending CSR response cleared.
// TESTING
//  1 write 0x80/0x280/0x480 to CSR0..2, read back -> identical values, status reads 0.
//  2 start, all ready=1, p_valid 1 cycle after grant -> q_valid all 1 at t+1, port 3 addr 0x98;
//    gemm_start_o at t+5; done pulse at t+9 -> STORE_C t+10, q_write=1, IDLE t+11, status=0b10.
//  3 LOAD_A with port 5 ready held 0 for 4 cycles -> only port 5 valid persists; LOAD_B delayed 4.
//  4 start and addr_a write during COMPUTE -> responses returned, sequence and addresses unchanged.
//  5 addr_a=0xFFFF_FFF8 with AW=32 -> port 1 address wraps to 0x0.
//  6 rst_i asserted in LOAD_B -> next cycle all outputs 0, status 0, CSR0 reads 0.

Source files
------------

// File: rtl/snax_gemm_seq_if.sv
// CSR request/response, TCDM request/response and datapath strobes of the GEMM sequencer.
// master = core/memory/datapath side, slave = the sequencer.
interface snax_gemm_seq_if #(
  parameter int AddrWidth     = 48,
  parameter int SnaxTcdmPorts = 16
);
  logic                                     csr_req_valid;
  logic                                     csr_req_ready;
  logic                                     csr_req_write;
  logic [31:0]                              csr_req_addr;
  logic [31:0]                              csr_req_data;
  logic                                     csr_rsp_valid;
  logic                                     csr_rsp_ready;
  logic [31:0]                              csr_rsp_data;
  logic [SnaxTcdmPorts-1:0]                 tcdm_q_valid;
  logic [SnaxTcdmPorts-1:0]                 tcdm_q_ready;
  logic                                     tcdm_q_write;
  logic [SnaxTcdmPorts-1:0][AddrWidth-1:0]  tcdm_q_addr;
  logic [SnaxTcdmPorts-1:0]                 tcdm_p_valid;
  logic [SnaxTcdmPorts-1:0]                 load_a;
  logic [SnaxTcdmPorts-1:0]                 load_b;
  logic                                     gemm_start;
  logic                                     gemm_done;

  modport master (
    output csr_req_valid, csr_req_write, csr_req_addr, csr_req_data, csr_rsp_ready,
    output tcdm_q_ready, tcdm_p_valid, gemm_done,
    input  csr_req_ready, csr_rsp_valid, csr_rsp_data,
    input  tcdm_q_valid, tcdm_q_write, tcdm_q_addr, load_a, load_b, gemm_start
  );

  modport slave (
    input  csr_req_valid, csr_req_write, csr_req_addr, csr_req_data, csr_rsp_ready,
    input  tcdm_q_ready, tcdm_p_valid, gemm_done,
    output csr_req_ready, csr_rsp_valid, csr_rsp_data,
    output tcdm_q_valid, tcdm_q_write, tcdm_q_addr, load_a, load_b, gemm_start
  );
endinterface

// File: rtl/snax_gemm_seq.sv
// SNAX GEMM control front-end: CSR decode, operand address generation and
// LOAD_A -> LOAD_B -> COMPUTE -> STORE_C phase sequencing over the TCDM ports.

// Per-port request tracker: holds valid until granted, then counts one read response.
module snax_gemm_seq_lane #(
  parameter int AW     = 48,
  parameter int OFFSET = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          active,
  input  logic          clr,
  input  logic [AW-1:0] base,
  input  logic          q_ready,
  input  logic          p_valid,
  output logic          q_valid,
  output logic [AW-1:0] addr,
  output logic          g_nxt,
  output logic          r_nxt,
  output logic          counted
);
  logic g_q, r_q;

  assign q_valid = active & ~g_q;
  // a response only counts once the grant has been registered in an earlier cycle
  assign counted = active & g_q & p_valid;
  assign g_nxt   = g_q | (q_valid & q_ready);
  assign r_nxt   = r_q | counted;
  assign addr    = active ? base + AW'(OFFSET) : '0;

  always_ff @(posedge clk) begin
    if (rst || clr || !active) begin
      g_q <= 1'b0;
      r_q <= 1'b0;
    end else begin
      g_q <= g_nxt;
      r_q <= r_nxt;
    end
  end
endmodule

module snax_gemm_seq #(
  parameter int AddrWidth     = 48,
  parameter int DataWidth     = 64,
  parameter int SnaxTcdmPorts = 16
) (
  input logic           clk,
  input logic           rst,
  snax_gemm_seq_if.slave bus
);
  localparam int P      = SnaxTcdmPorts;
  localparam int AW     = AddrWidth;
  localparam int STRIDE = DataWidth / 8;

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, COMPUTE, STORE_C} state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
  } csr_req_t;

  state_e          state_q, state_d;
  csr_req_t        req;
  logic            accept, start_cmd, launch, busy;
  logic [31:0]     addr_a_q, addr_b_q, addr_c_q;
  logic [AW-1:0]   base_a_q, base_b_q, base_c_q, base_sel;
  logic            done_q, started_q;
  logic            rsp_valid_q;
  logic [31:0]     rsp_data_q, rdata;
  logic            active, clr, gemm_start;
  logic [P-1:0]    q_valid, g_nxt, r_nxt, counted;
  logic [P-1:0][AW-1:0] addr;

  assign req = '{write: bus.csr_req_write, addr: bus.csr_req_addr, data: bus.csr_req_data};

  // single outstanding CSR transaction; ready is also held low while in reset
  assign bus.csr_req_ready = ~rsp_valid_q & ~rst;
  assign accept            = bus.csr_req_valid & bus.csr_req_ready;
  assign start_cmd         = accept & req.write & (req.addr == 32'd3);
  assign busy              = (state_q != IDLE);
  assign launch            = start_cmd & ~busy;

  always_comb begin
    rdata = '0;
    if (!req.write) begin
      case (req.addr)
        32'd0:   rdata = addr_a_q;
        32'd1:   rdata = addr_b_q;
        32'd2:   rdata = addr_c_q;
        32'd4:   rdata = {30'd0, done_q, busy};
        default: rdata = '0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    clr        = 1'b0;
    gemm_start = 1'b0;
    active     = 1'b0;
    base_sel   = '0;
    case (state_q)
      IDLE: if (launch) state_d = LOAD_A;
      LOAD_A: begin
        active   = 1'b1;
        base_sel = base_a_q;
        if (&g_nxt && &r_nxt) begin
          state_d = LOAD_B;
          clr     = 1'b1;
        end
      end
      LOAD_B: begin
        active   = 1'b1;
        base_sel = base_b_q;
        if (&g_nxt && &r_nxt) begin
          state_d = COMPUTE;
          clr     = 1'b1;
        end
      end
      COMPUTE: begin
        gemm_start = ~started_q;
        if (bus.gemm_done) state_d = STORE_C;
      end
      STORE_C: begin
        active   = 1'b1;
        base_sel = base_c_q;
        if (&g_nxt) begin
          state_d = IDLE;
          clr     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      addr_c_q    <= '0;
      base_a_q    <= '0;
      base_b_q    <= '0;
      base_c_q    <= '0;
      done_q      <= 1'b0;
      started_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= (state_q == COMPUTE);
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= rdata;
        if (req.write && !busy) begin
          case (req.addr)
            32'd0:   addr_a_q <= req.data;
            32'd1:   addr_b_q <= req.data;
            32'd2:   addr_c_q <= req.data;
            default: ;
          endcase
        end
      end else if (rsp_valid_q && bus.csr_rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
      // bases are snapshotted so CSR traffic during a run cannot disturb it
      if (launch) begin
        done_q   <= 1'b0;
        base_a_q <= AW'(addr_a_q);
        base_b_q <= AW'(addr_b_q);
        base_c_q <= AW'(addr_c_q);
      end
      if (state_q == STORE_C && &g_nxt) done_q <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    snax_gemm_seq_lane #(
      .AW     (AW),
      .OFFSET (gi * STRIDE)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .active  (active),
      .clr     (clr),
      .base    (base_sel),
      .q_ready (bus.tcdm_q_ready[gi]),
      .p_valid (bus.tcdm_p_valid[gi]),
      .q_valid (q_valid[gi]),
      .addr    (addr[gi]),
      .g_nxt   (g_nxt[gi]),
      .r_nxt   (r_nxt[gi]),
      .counted (counted[gi])
    );
  end

  assign bus.tcdm_q_valid  = q_valid;
  assign bus.tcdm_q_addr   = addr;
  assign bus.tcdm_q_write  = (state_q == STORE_C);
  assign bus.load_a        = counted & {P{state_q == LOAD_A}};
  assign bus.load_b        = counted & {P{state_q == LOAD_B}};
  assign bus.gemm_start    = gemm_start;
  assign bus.csr_rsp_valid = rsp_valid_q;
  assign bus.csr_rsp_data  = rsp_data_q;
endmodule
